fifo_ctrl: RTL

//  Control end of the synchronous FIFO: owns head/tail pointers, occupancy count, status flags.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_addr_calc.sv | 50 +++++
 rtl/fifo_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO control block: size defaults and the
// status-state encoding. The status state is a set of outcome bits so that
// combined outcomes (e.g. a refused write alongside an accepted read) are
// representable; the named constants cover every reachable combination's parts.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = 3;
  localparam int FIFO_DW    = 32;

  localparam int ST_W = 4;

  // Bit positions of each outcome inside the status state.
  localparam int ST_BIT_WR_ACK = 0;
  localparam int ST_BIT_WR_ERR = 1;
  localparam int ST_BIT_RD_ACK = 2;
  localparam int ST_BIT_RD_ERR = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 4'b0000;
  localparam logic [ST_W-1:0] ST_WRITE  = 4'b0001;
  localparam logic [ST_W-1:0] ST_WR_ERR = 4'b0010;
  localparam logic [ST_W-1:0] ST_READ   = 4'b0100;
  localparam logic [ST_W-1:0] ST_RD_ERR = 4'b1000;
  localparam logic [ST_W-1:0] ST_RW     = ST_WRITE | ST_READ;

endpackage

// File: rtl/fifo_addr_calc.sv
// Next-state logic for the FIFO control block: decides which requests are
// accepted this cycle and computes the next head, tail, occupancy and status.
// Purely combinational; all state lives in fifo_ctrl.
module fifo_addr_calc
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW
) (
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic            full,
  input  logic            empty,
  input  logic [AW-1:0]   head,
  input  logic [AW-1:0]   tail,
  input  logic [AW:0]     count,
  output logic            wr_ok,
  output logic            rd_ok,
  output logic [AW-1:0]   head_nxt,
  output logic [AW-1:0]   tail_nxt,
  output logic [AW:0]     count_nxt,
  output logic [ST_W-1:0] state_nxt
);

  // Acceptance, pointer advance, occupancy update and outcome bits.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    wr_ok     = wr_en & ~full;
    rd_ok     = rd_en & ~empty;
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    state_nxt = ST_IDLE;

    // Depth is a power of two, so the natural AW-bit rollover gives 7 -> 0.
    if (wr_ok) tail_nxt = tail + 1'b1;
    if (rd_ok) head_nxt = head + 1'b1;

    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase

    if (wr_ok)      state_nxt = state_nxt | ST_WRITE;
    else if (wr_en) state_nxt = state_nxt | ST_WR_ERR;
    if (rd_ok)      state_nxt = state_nxt | ST_READ;
    else if (rd_en) state_nxt = state_nxt | ST_RD_ERR;
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Control end of the 8-deep synchronous FIFO: owns head/tail pointers,
// occupancy and status flags, drives the register file's write side and
// read address, and registers the returned read word onto d_out.
// Optional feature macro: FIFO_ALMOST_FLAGS_EN adds almost_full/almost_empty.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [DW-1:0] d_in,
  input  logic [DW-1:0] rData,
  output logic          we,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] wData,
  output logic [AW-1:0] rAddr,
  output logic [DW-1:0] d_out,
  output logic          full,
  output logic          empty,
  output logic          wr_ack,
  output logic          wr_err,
  output logic          rd_ack,
  output logic          rd_err,
  output logic [AW:0]   data_count
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic          almost_full,
  output logic          almost_empty
`endif
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]   head, tail, head_nxt, tail_nxt;
  logic [AW:0]     count, count_nxt;
  logic [ST_W-1:0] state, state_nxt;
  logic            wr_ok, rd_ok;

  fifo_addr_calc #(.AW(AW)) u_addr_calc (
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .tail      (tail),
    .count     (count),
    .wr_ok     (wr_ok),
    .rd_ok     (rd_ok),
    .head_nxt  (head_nxt),
    .tail_nxt  (tail_nxt),
    .count_nxt (count_nxt),
    .state_nxt (state_nxt)
  );

  // Occupancy flags and register-file interface decode.
  always_comb begin
    full       = (count == FULL_COUNT);
    empty      = (count == '0);
    // Held low during reset so a write coinciding with reset never lands.
    we         = wr_ok & reset_n;
    wAddr      = tail;
    wData      = d_in;
    rAddr      = head;
    data_count = count;
    wr_ack     = state[ST_BIT_WR_ACK];
    wr_err     = state[ST_BIT_WR_ERR];
    rd_ack     = state[ST_BIT_RD_ACK];
    rd_err     = state[ST_BIT_RD_ERR];
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  // Early-warning flags one entry from either end.
  always_comb begin
    almost_full  = (count == FULL_COUNT - 1'b1);
    almost_empty = (count == (AW+1)'(1));
  end
`endif

  // Pointer, occupancy, status and read-data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: only control state is reset; the register file keeps stale words, which is harmless since count gates every read.
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= ST_IDLE;
      d_out <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
      state <= state_nxt;
      if (rd_ok) d_out <= rData;
    end
  end

endmodule
